// File: rtl/hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : hazard_ctrl_if
// Description : Pipeline hazard control bundle. The master side drives the
//               stage information and the slave side drives the register controls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       rs_D;
    logic             rs_used_D;
    logic [2:0]       rt_D;
    logic             rt_used_D;
    logic             halt_D;
    logic [2:0]       rd_EX;
    logic             rf_writeEn_EX;
    logic [1:0]       memreg_EX;
    logic [2:0]       rd_MEM;
    logic             rf_writeEn_MEM;
    logic             branch_taken_EX;
    logic             imem_ready;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             dex_en;
    logic             dex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_D, rs_used_D, rt_D, rt_used_D, halt_D,
        output rd_EX, rf_writeEn_EX, memreg_EX, rd_MEM, rf_writeEn_MEM,
        output branch_taken_EX, imem_ready,
        input  pc_en, fd_en, fd_flush, dex_en, dex_bubble, halted, stall_cnt
    );

    modport slave (
        input  rs_D, rs_used_D, rt_D, rt_used_D, halt_D,
        input  rd_EX, rf_writeEn_EX, memreg_EX, rd_MEM, rf_writeEn_MEM,
        input  branch_taken_EX, imem_ready,
        output pc_en, fd_en, fd_flush, dex_en, dex_bubble, halted, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : hazard_ctrl
// Description : F/D and D/EX pipeline register control. It handles RAW stalls,
//               branch squash, imem wait and halt drain, and it counts stall cycles.
//               Define FORWARD_EN to restrict stalls to load-use against EX.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hazard_ctrl_if.slave bus
);

    localparam int               c_DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_DW-1:0]  c_DRAIN_LOAD = c_DW'(DRAIN_CYC - 1);
    localparam logic [1:0]       c_ST_RUN     = 2'd0;
    localparam logic [1:0]       c_ST_DRAIN   = 2'd1;
    localparam logic [1:0]       c_ST_HALTED  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_DW-1:0]  r_drain;
    logic [c_DW-1:0]  w_drain_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_pc_en;
    logic             w_fd_en;
    logic             w_fd_flush;
    logic             w_dex_en;
    logic             w_dex_bubble;
    logic             w_count;
    logic             w_hazard;

    function automatic logic f_src_match(
        input logic [2:0] rs, input logic rs_used,
        input logic [2:0] rt, input logic rt_used,
        input logic [2:0] dst
    );
        return (rs_used && (rs == dst)) || (rt_used && (rt == dst));
    endfunction

`ifdef FORWARD_EN
    // Forwarding covers everything except a load still in EX.
    logic w_unused_mem;
    assign w_unused_mem = ^{bus.rd_MEM, bus.rf_writeEn_MEM};
    assign w_hazard = bus.rf_writeEn_EX && (bus.memreg_EX == 2'b01) &&
                      f_src_match(bus.rs_D, bus.rs_used_D, bus.rt_D, bus.rt_used_D, bus.rd_EX);
`else
    // The WB stage is covered by RF write-through, so only EX and MEM are checked.
    logic w_unused_memreg;
    assign w_unused_memreg = ^bus.memreg_EX;
    assign w_hazard =
        (bus.rf_writeEn_EX &&
         f_src_match(bus.rs_D, bus.rs_used_D, bus.rt_D, bus.rt_used_D, bus.rd_EX)) ||
        (bus.rf_writeEn_MEM &&
         f_src_match(bus.rs_D, bus.rs_used_D, bus.rt_D, bus.rt_used_D, bus.rd_MEM));
`endif

    always_comb begin
        w_pc_en      = 1'b0;
        w_fd_en      = 1'b0;
        w_fd_flush   = 1'b0;
        w_dex_en     = 1'b0;
        w_dex_bubble = 1'b0;
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain;
        case (r_state)
            c_ST_RUN: begin
                if (bus.branch_taken_EX) begin
                    w_pc_en      = 1'b1;
                    w_fd_en      = 1'b1;
                    w_fd_flush   = 1'b1;
                    w_dex_en     = 1'b1;
                    w_dex_bubble = 1'b1;
                end else if (w_hazard) begin
                    w_dex_en     = 1'b1;
                    w_dex_bubble = 1'b1;
                end else if (bus.halt_D) begin
                    w_fd_en     = 1'b1;
                    w_fd_flush  = 1'b1;
                    w_dex_en    = 1'b1;
                    w_state_nxt = c_ST_DRAIN;
                    w_drain_nxt = c_DRAIN_LOAD;
                end else if (!bus.imem_ready) begin
                    w_fd_en    = 1'b1;
                    w_fd_flush = 1'b1;
                    w_dex_en   = 1'b1;
                end else begin
                    w_pc_en  = 1'b1;
                    w_fd_en  = 1'b1;
                    w_dex_en = 1'b1;
                end
            end
            c_ST_DRAIN: begin
                // Halt is the youngest instruction, so branches and hazards are not possible here.
                w_fd_en      = 1'b1;
                w_fd_flush   = 1'b1;
                w_dex_en     = 1'b1;
                w_dex_bubble = 1'b1;
                if (r_drain == '0) begin
                    w_state_nxt = c_ST_HALTED;
                end else begin
                    w_drain_nxt = r_drain - c_DW'(1);
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
        if (!rst) begin
            w_pc_en      = 1'b0;
            w_fd_en      = 1'b0;
            w_fd_flush   = 1'b0;
            w_dex_en     = 1'b0;
            w_dex_bubble = 1'b0;
        end
    end

    assign w_count = rst && (r_state != c_ST_HALTED) && (!w_pc_en || w_dex_bubble);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_RUN;
            r_drain     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            if (w_count && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.fd_en      = w_fd_en;
    assign bus.fd_flush   = w_fd_flush;
    assign bus.dex_en     = w_dex_en;
    assign bus.dex_bubble = w_dex_bubble;
    assign bus.halted     = (r_state == c_ST_HALTED);
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl, using directed and random stimulus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        bit pc;
        bit fd;
        bit fl;
        bit dex;
        bit bub;
        bit hlt;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks;
    int   passed;

    // reference model state
    bit   m_halted;
    bit   m_drain;
    int   m_left;
    int   m_cnt;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit reads(input int dst);
        return (bus.rs_used_D && bus.rs_D == 3'(dst)) || (bus.rt_used_D && bus.rt_D == 3'(dst));
    endfunction

    function automatic bit model_hazard();
`ifdef FORWARD_EN
        return bus.rf_writeEn_EX && bus.memreg_EX == 2'b01 && reads(int'(bus.rd_EX));
`else
        return (bus.rf_writeEn_EX && reads(int'(bus.rd_EX))) ||
               (bus.rf_writeEn_MEM && reads(int'(bus.rd_MEM)));
`endif
    endfunction

    // The expectation for this cycle comes from the pre-edge model state; the state then advances.
    task automatic model_eval();
        exp_t e;
        e = '{pc: 0, fd: 0, fl: 0, dex: 0, bub: 0, hlt: 0, cnt: 0};
        if (!rst) begin
            m_halted = 0; m_drain = 0; m_left = 0; m_cnt = 0;
            exp_q.push_back(e);
            return;
        end
        e.cnt = m_cnt;
        e.hlt = m_halted;
        if (m_halted) begin
            exp_q.push_back(e);
            return;
        end
        if (m_drain) begin
            e.fd = 1; e.fl = 1; e.dex = 1; e.bub = 1;
            if (m_left == 0) begin m_drain = 0; m_halted = 1; end
            else m_left--;
        end else if (bus.branch_taken_EX) begin
            e.pc = 1; e.fd = 1; e.fl = 1; e.dex = 1; e.bub = 1;
        end else if (model_hazard()) begin
            e.dex = 1; e.bub = 1;
        end else if (bus.halt_D) begin
            e.fd = 1; e.fl = 1; e.dex = 1;
            m_drain = 1; m_left = DRAIN_CYC - 1;
        end else if (!bus.imem_ready) begin
            e.fd = 1; e.fl = 1; e.dex = 1;
        end else begin
            e.pc = 1; e.fd = 1; e.dex = 1;
        end
        if (!e.pc || e.bub) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        exp_q.push_back(e);
    endtask

    task automatic do_cycle(
        input logic r, input logic [2:0] rs, input logic rsu, input logic [2:0] rt,
        input logic rtu, input logic hlt, input logic [2:0] rdex, input logic weex,
        input logic [1:0] mr, input logic [2:0] rdmem, input logic wemem,
        input logic br, input logic imr
    );
        @(posedge clk);
        #1;
        rst                 = r;
        bus.rs_D            = rs;
        bus.rs_used_D       = rsu;
        bus.rt_D            = rt;
        bus.rt_used_D       = rtu;
        bus.halt_D          = hlt;
        bus.rd_EX           = rdex;
        bus.rf_writeEn_EX   = weex;
        bus.memreg_EX       = mr;
        bus.rd_MEM          = rdmem;
        bus.rf_writeEn_MEM  = wemem;
        bus.branch_taken_EX = br;
        bus.imem_ready      = imr;
        model_eval();
    endtask

    task automatic idle(input logic r, input logic imr);
        do_cycle(r, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, imr);
    endtask

    task automatic rand_cycle(input logic r);
        do_cycle(r, 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom_range(0, 24) == 0), 3'($urandom_range(0, 3)), 1'($urandom),
                 2'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
    endtask

    // Compares every presented output against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_en",      int'(bus.pc_en),      int'(e.pc));
            chk("fd_en",      int'(bus.fd_en),      int'(e.fd));
            chk("fd_flush",   int'(bus.fd_flush),   int'(e.fl));
            chk("dex_en",     int'(bus.dex_en),     int'(e.dex));
            chk("dex_bubble", int'(bus.dex_bubble), int'(e.bub));
            chk("halted",     int'(bus.halted),     int'(e.hlt));
            chk("stall_cnt",  int'(bus.stall_cnt),  e.cnt);
        end
    end

    initial begin
        checks = 0; passed = 0;
        m_halted = 0; m_drain = 0; m_left = 0; m_cnt = 0;
        rst = 1'b0;
        bus.rs_D = '0; bus.rs_used_D = 0; bus.rt_D = '0; bus.rt_used_D = 0;
        bus.halt_D = 0; bus.rd_EX = '0; bus.rf_writeEn_EX = 0; bus.memreg_EX = '0;
        bus.rd_MEM = '0; bus.rf_writeEn_MEM = 0; bus.branch_taken_EX = 0; bus.imem_ready = 0;

        // reset with random inputs, then release with clean inputs
        repeat (3) rand_cycle(1'b0);
        repeat (2) idle(1'b1, 1'b1);

        // ALU RAW: match in EX, then MEM, then clear
        do_cycle(1, 3'd3, 1, 3'd0, 0, 0, 3'd3, 1, 2'b00, 3'd0, 0, 0, 1);
        do_cycle(1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 2'b00, 3'd3, 1, 0, 1);
        do_cycle(1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 2'b00, 3'd0, 0, 0, 1);

        // load-use on rt
        do_cycle(1, 3'd0, 0, 3'd5, 1, 0, 3'd5, 1, 2'b01, 3'd0, 0, 0, 1);
        idle(1'b1, 1'b1);

        // branch and hazard in the same cycle
        do_cycle(1, 3'd3, 1, 3'd0, 0, 1, 3'd3, 1, 2'b00, 3'd0, 0, 1, 1);
        idle(1'b1, 1'b1);

        // halt, then reset mid-drain
        do_cycle(1, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 2'b00, 3'd0, 0, 0, 1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        repeat (2) idle(1'b1, 1'b1);

        // halt through drain to sticky halted
        do_cycle(1, 3'd0, 0, 3'd0, 0, 1, 3'd0, 0, 2'b00, 3'd0, 0, 0, 1);
        repeat (6) rand_cycle(1'b1);

        // imem wait long enough to saturate the counter
        idle(1'b0, 1'b1);
        repeat ((1 << CNT_W) + 5) idle(1'b1, 1'b0);

        // random traffic with occasional reset to escape halt
        repeat (400) rand_cycle(1'($urandom_range(0, 39) != 0));
        idle(1'b1, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer-side controller for the D/EX pipeline register and the F/D register of the 5-stage core.
- Reads EX/MEM destination info and D-stage source info, and generates the enable, flush and bubble controls that the pipeline registers sample.
- Resolves three cases: RAW data hazards, taken-branch squash, and instruction-memory wait.
- Sequences halt drain, and counts stall cycles for performance debug.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter
DRAIN_CYC, 3, cycles from halt entering EX until halted asserts (EX, M, WB)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rs_D  in  3  D-stage source reg A
rs_used_D  in  1  D instruction reads rs
rt_D  in  3  D-stage source reg B
rt_used_D  in  1  D instruction reads rt
halt_D  in  1  D-stage instruction is HALT
rd_EX  in  3  EX-stage destination reg (rf_sel_out of D/EX)
rf_writeEn_EX  in  1  EX instruction writes RF
memreg_EX  in  2  EX writeback source; 2'b01 = load
rd_MEM  in  3  MEM-stage destination reg
rf_writeEn_MEM  in  1  MEM instruction writes RF
branch_taken_EX  in  1  EX resolved taken branch/jump
imem_ready  in  1  instruction memory returned valid fetch this cycle
pc_en  out  1  PC update enable
fd_en  out  1  F/D register enable
fd_flush  out  1  load NOP into F/D
dex_en  out  1  D/EX register enable
dex_bubble  out  1  zero all D/EX control fields (NOP)
halted  out  1  sticky: processor fully halted
stall_cnt  out  CNT_W  saturating count of stall/bubble cycles

Behaviour:
- Reset: rst low asynchronously forces state RUN, drain counter 0, halted 0, stall_cnt 0. While rst is low, pc_en, fd_en and dex_en are 0, and fd_flush and dex_bubble are 0.
- States: RUN, DRAIN, HALTED; registered. All other outputs are combinational from the state and inputs, valid in the same cycle.
- RAW hazard (default build): hazard = src match against EX dest (rf_writeEn_EX) or MEM dest (rf_writeEn_MEM), where src match = (rs_used_D & rs_D==dst) | (rt_used_D & rt_D==dst). RF write-through covers the WB stage, so no WB check is needed.
- RUN, priority highest first, one action per cycle:
  - branch_taken_EX: pc_en=1, fd_en=1, fd_flush=1, dex_en=1, dex_bubble=1. halt_D is ignored because it is squashed.
  - hazard: pc_en=0, fd_en=0, dex_en=1, dex_bubble=1. Hazard is re-evaluated each cycle and stall length follows naturally.
  - halt_D: dex_en=1 (halt passes to EX), pc_en=0, fd_en=1, fd_flush=1. Go to DRAIN with counter=DRAIN_CYC-1.
  - !imem_ready: pc_en=0, fd_en=1, fd_flush=1, dex_en=1.
  - else: all enables 1, no flush or bubble.
- DRAIN:
  - pc_en=0, fd_en=1, fd_flush=1, dex_en=1, dex_bubble=1.
  - branch_taken_EX and hazard are ignored; they are impossible, since halt is youngest.
  - Counter decrements each cycle; at 0, go to HALTED.
- HALTED: halted=1, all enables 0, flush/bubble 0. Leaves only on reset.
- stall_cnt increments by 1 in any cycle with rst high and state!=HALTED in which pc_en=0 or dex_bubble=1. It saturates at all-ones and does not wrap.
- Reset asserted mid-DRAIN or mid-stall: immediate return to RUN with counters cleared.

Optional Feature:
FORWARD_EN:
- Defined: the EX/MEM/WB forwarding network exists. hazard = src match against EX dest only when rf_writeEn_EX & memreg_EX==2'b01 (load-use). Stall length is exactly 1 cycle; MEM matches are never hazards.
- Undefined: full RAW stall as described above.
- Ports are identical in both builds.

Test Plan:
- Reset: rst=0 with random inputs -> all outputs 0, stall_cnt=0. Release rst with clean inputs -> pc_en=fd_en=dex_en=1 next cycle.
- ALU RAW, default build: rd_EX=3, rf_writeEn_EX=1, rs_D=3, rs_used_D=1 -> pc_en=0, dex_bubble=1. Advance rd to MEM -> still stalled. Clear -> resumes; stall_cnt=2. With FORWARD_EN: no stall.
- Load-use, FORWARD_EN: memreg_EX=2'b01, rd_EX=5, rt_D=5 -> exactly 1 bubble cycle; stall_cnt=1.
- Branch vs hazard same cycle: branch_taken_EX=1 and hazard=1 -> fd_flush=1, dex_bubble=1, pc_en=1 (flush wins).
- Halt: halt_D=1 in RUN -> DRAIN, pc_en=0 for 3 cycles, then halted=1 sticky. Assert rst mid-DRAIN -> halted stays 0, back to RUN.
- imem wait plus saturation: imem_ready=0 for 2^CNT_W+5 cycles (CNT_W=4) -> fd_flush=1 each cycle, stall_cnt holds at 4'hF.
